psram_cmd_scheduler: RTL and testbench
======================================

Name: psram_cmd_scheduler

Overview:
- Shares the single PSRAM controller command port between two burst requesters: m1 (framebuffer, high priority) and m2 (debug burst writer).
- Enforces the controller's command spacing (Tcmd) without a coarse busy timeout.
- Tags outstanding reads and steers returning rd_data_valid beats to the requester that issued them, so the next command can be issued while a read is still returning.

Parameters:
- CMD_INTERVAL, 14: minimum clocks from one downstream cmd_en to the next.
- BEATS_PER_BURST, 4: 64-bit beats per read or write burst.
- TAG_DEPTH, 4: maximum outstanding reads (power of 2).
- M1_STREAK_MAX, 3: consecutive m1 grants allowed while m2 is waiting before m2 is forced.

Ports:
- clk  in  1  system clock (controller clk_out domain).
- sys_resetn  in  1  asynchronous, active-low reset.
- calib  in  1  controller init_calib; no grants while low.
- mN_req (N=1,2)  in  1  command request; held until mN_ack.
- mN_cmd  in  1  0=read, 1=write.
- mN_addr  in  21  burst address.
- mN_wr_data  in  64  write beat; beat k valid at cycle ack+k.
- mN_data_mask  in  8  byte mask accompanying mN_wr_data.
- mN_ack  out  1  one-cycle grant pulse, coincident with downstream cmd_en.
- mN_rd_data_valid  out  1  read beat for requester N.
- rd_data_out  out  64  read data, passed through from rd_data.
- mem_cmd  out  1  to controller cmd.
- mem_cmd_en  out  1  to controller cmd_en.
- mem_addr  out  21  to controller addr.
- mem_wr_data  out  64  to controller wr_data.
- mem_data_mask  out  8  to controller data_mask.
- rd_data  in  64  from controller.
- rd_data_valid  in  1  from controller.
- tag_error  out  1  sticky: data beat arrived with no outstanding read.

Behaviour:
- Reset (async, sys_resetn low) clears:
  - all acks and mem_cmd_en, spacing counter, tag FIFO, beat counters, streak counter and tag_error;
  - mem_addr, mem_wr_data, mem_data_mask and mem_cmd to 0.
- A reset asserted mid-burst discards all in-flight state; no rd_data_valid is routed until a new read issues.
- can_issue = calib && spacing==0 && !write_window && !(candidate is read && tag FIFO full).
- Arbitration, evaluated each cycle when can_issue:
  - m1 wins if m1_req, unless m2_req && streak==M1_STREAK_MAX, in which case m2 wins.
  - streak increments on each m1 grant while m2_req is high; it resets on any m2 grant or when m2_req is low.
- Grant, registered; the grant cycle is the cycle the registers update:
  - mem_cmd_en=1 and mem_cmd/mem_addr are taken from the winner; mN_ack=1 in that same cycle.
  - spacing loads CMD_INTERVAL-1 and counts down to 0; the next grant is at the earliest CMD_INTERVAL cycles later.
- Requesters must drop mN_req the cycle after ack or present a new command. A request still high at the next can_issue is a new command.
- Write bursts:
  - write_window spans BEATS_PER_BURST cycles starting at the grant cycle.
  - mem_wr_data/mem_data_mask = granted master's wr_data/data_mask, combinational mux, during the window; 0 outside it.
  - Beat 0 must be valid on the requester side in the ack cycle.
- Read tagging:
  - On a read grant, push the requester id into the tag FIFO.
  - Each rd_data_valid increments the beat counter. mN_rd_data_valid = rd_data_valid && FIFO non-empty && head==N.
  - On beat BEATS_PER_BURST-1 the counter wraps to 0 and the FIFO pops.
  - A push and pop in the same cycle are both honoured; occupancy is unchanged.
- rd_data_valid with an empty FIFO sets tag_error; that beat is dropped (no mN_rd_data_valid).
- If calib falls: the spacing counter and any write window finish normally, no new grants are made, and outstanding read tags are retained.
- A read request with a full FIFO is not granted. A pending write from the other master may be granted instead, per the normal priority rules.
- rd_data_out = rd_data, combinational, zero latency.

Test Plan:
- calib=1, m1 read at addr 0x000100 -> mem_cmd_en pulse with mem_cmd=0 and mem_addr=0x000100, m1_ack in the same cycle; after 4 rd_data_valid beats -> m1_rd_data_valid high for exactly those 4 beats, m2_rd_data_valid stays 0.
- m1 and m2 both requesting continuously -> grant order m1,m1,m1,m2,m1,m1,m1,m2; successive mem_cmd_en exactly 14 cycles apart.
- m2 write with beats 0xA..0xD, mask 0xFF -> mem_wr_data = 0xA,0xB,0xC,0xD on grant cycle +0..+3, then 0.
- Five back-to-back reads issued before any data returns -> 4 granted; the 5th is held until the first burst's 4th beat pops the FIFO.
- rd_data_valid pulsed with no outstanding read -> tag_error=1 and stays 1 until reset; sys_resetn low mid-read -> FIFO empty, all outputs 0.
- calib=0 with both requests high -> no mem_cmd_en; calib rises -> first grant goes to m1 in the next cycle.

Source files
------------

// File: rtl/psram_cmd_scheduler.sv
// psram_cmd_scheduler: arbitrates two burst masters onto one PSRAM command port,
// spacing commands by CMD_INTERVAL and steering read beats back through a tag FIFO.
module psram_cmd_scheduler #(
  parameter int CMD_INTERVAL    = 14,
  parameter int BEATS_PER_BURST = 4,
  parameter int TAG_DEPTH       = 4,
  parameter int M1_STREAK_MAX   = 3
) (
  input  logic        clk,
  input  logic        sys_resetn,
  input  logic        calib,
  input  logic        m1_req,
  input  logic        m1_cmd,
  input  logic [20:0] m1_addr,
  input  logic [63:0] m1_wr_data,
  input  logic [7:0]  m1_data_mask,
  output logic        m1_ack,
  output logic        m1_rd_data_valid,
  input  logic        m2_req,
  input  logic        m2_cmd,
  input  logic [20:0] m2_addr,
  input  logic [63:0] m2_wr_data,
  input  logic [7:0]  m2_data_mask,
  output logic        m2_ack,
  output logic        m2_rd_data_valid,
  output logic [63:0] rd_data_out,
  output logic        mem_cmd,
  output logic        mem_cmd_en,
  output logic [20:0] mem_addr,
  output logic [63:0] mem_wr_data,
  output logic [7:0]  mem_data_mask,
  input  logic [63:0] rd_data,
  input  logic        rd_data_valid,
  output logic        tag_error
);
  localparam int SW = $clog2(CMD_INTERVAL + 1);
  localparam int BW = $clog2(BEATS_PER_BURST + 1);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int KW = $clog2(M1_STREAK_MAX + 1);
  logic [SW-1:0] spacing_q, spacing_d;
  logic [BW-1:0] wleft_q, wleft_d, beat_q, beat_d;
  logic [PW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [TAG_DEPTH-1:0] tags_q, tags_d;
  logic [KW-1:0] streak_q, streak_d;
  logic wsel_q, wsel_d, tag_error_q, tag_error_d;
  logic m1_ack_q, m1_ack_d, m2_ack_q, m2_ack_d, mem_cmd_q, mem_cmd_d;
  logic [20:0] mem_addr_q, mem_addr_d;
  logic empty, full, head, hit, elig1, elig2, can_issue, gnt1, gnt2, push, pop;
  always_comb begin
    empty = wptr_q == rptr_q;
    full = (wptr_q - rptr_q) == (PW+1)'(TAG_DEPTH);
    head = tags_q[rptr_q[PW-1:0]];
    hit = rd_data_valid && !empty;
    // a read blocked by a full tag FIFO drops out so the other master's write can go
    elig1 = m1_req && (m1_cmd || !full);
    elig2 = m2_req && (m2_cmd || !full);
    can_issue = calib && spacing_q == '0 && wleft_q == '0;
    gnt2 = can_issue && elig2 && (!elig1 || streak_q == KW'(M1_STREAK_MAX));
    gnt1 = can_issue && elig1 && !gnt2;
    push = (gnt1 && !m1_cmd) || (gnt2 && !m2_cmd);
    pop = hit && beat_q == BW'(BEATS_PER_BURST - 1);
    spacing_d = (gnt1 || gnt2) ? SW'(CMD_INTERVAL - 1) : spacing_q != '0 ? spacing_q - SW'(1) : '0;
    wleft_d = ((gnt1 && m1_cmd) || (gnt2 && m2_cmd)) ? BW'(BEATS_PER_BURST) : wleft_q != '0 ? wleft_q - BW'(1) : '0;
    wsel_d = (gnt1 || gnt2) ? gnt2 : wsel_q;
    beat_d = hit ? (pop ? '0 : beat_q + BW'(1)) : beat_q;
    wptr_d = wptr_q + (PW+1)'(push);
    rptr_d = rptr_q + (PW+1)'(pop);
    streak_d = (!m2_req || gnt2) ? '0 : (gnt1 && streak_q != KW'(M1_STREAK_MAX)) ? streak_q + KW'(1) : streak_q;
    tag_error_d = tag_error_q || (rd_data_valid && empty);
    m1_ack_d = gnt1;
    m2_ack_d = gnt2;
    mem_cmd_d = gnt1 ? m1_cmd : gnt2 ? m2_cmd : mem_cmd_q;
    mem_addr_d = gnt1 ? m1_addr : gnt2 ? m2_addr : mem_addr_q;
    tags_d = tags_q;
    if (push) tags_d[wptr_q[PW-1:0]] = gnt2;
  end
  always_ff @(posedge clk or negedge sys_resetn)
    if (!sys_resetn) begin
      spacing_q <= '0;
      wleft_q <= '0;
      beat_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      tags_q <= '0;
      streak_q <= '0;
      wsel_q <= 1'b0;
      tag_error_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m2_ack_q <= 1'b0;
      mem_cmd_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      spacing_q <= spacing_d;
      wleft_q <= wleft_d;
      beat_q <= beat_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      tags_q <= tags_d;
      streak_q <= streak_d;
      wsel_q <= wsel_d;
      tag_error_q <= tag_error_d;
      m1_ack_q <= m1_ack_d;
      m2_ack_q <= m2_ack_d;
      mem_cmd_q <= mem_cmd_d;
      mem_addr_q <= mem_addr_d;
    end
  assign m1_ack = m1_ack_q;
  assign m2_ack = m2_ack_q;
  assign mem_cmd_en = m1_ack_q || m2_ack_q;
  assign mem_cmd = mem_cmd_q;
  assign mem_addr = mem_addr_q;
  // write beats stream straight from the granted master for the whole window
  assign mem_wr_data = wleft_q != '0 ? (wsel_q ? m2_wr_data : m1_wr_data) : '0;
  assign mem_data_mask = wleft_q != '0 ? (wsel_q ? m2_data_mask : m1_data_mask) : '0;
  assign m1_rd_data_valid = hit && !head;
  assign m2_rd_data_valid = hit && head;
  assign rd_data_out = rd_data;
  assign tag_error = tag_error_q;
endmodule

// File: tb/tb_psram_cmd_scheduler.sv
// tb_psram_cmd_scheduler: random two-master traffic against a queue-based scoreboard
// that predicts grants, write beats and read-beat routing.
module tb_psram_cmd_scheduler;
  typedef struct packed {
    logic cmd;
    logic [20:0] addr;
    logic [3:0][63:0] d;
    logic [3:0][7:0] mk;
  } item_t;
  logic clk = 1'b0, sys_resetn = 1'b0, calib = 1'b0;
  logic [1:0] req = '0, cmd = '0, ack, rdv_o;
  logic [1:0][20:0] addr = '0;
  logic [1:0][63:0] wd = '0;
  logic [1:0][7:0] mk = '0;
  logic [63:0] rd_data_out, mem_wr_data, rdd = '0;
  logic mem_cmd, mem_cmd_en, tag_error, rdv_i = 1'b0;
  logic [20:0] mem_addr;
  logic [7:0] mem_data_mask;
  int checks = 0, errors = 0, cyc = 0;
  int mode[2] = '{0, 0}, ncmd[2] = '{0, 0}, gapmax[2] = '{0, 0}, fix_addr[2] = '{-1, -1};
  bit pat_wd = 0, hold = 0, stray = 0, pop_arm = 0;
  int cpend = 0, cbeat = 0, first_pop = -1;
  item_t q0[$], q1[$], pend_it, wit;
  int pend_m = -1, last_g = -1000, streak = 0, bcnt = 0, wl = 0, wrec = 0;
  bit terr = 0;
  bit tq[$];
  int glog[$], gcyc[$];
  logic [63:0] wlog[$];
  int rdv_cnt[2] = '{0, 0};

  psram_cmd_scheduler dut (
    .clk(clk), .sys_resetn(sys_resetn), .calib(calib),
    .m1_req(req[0]), .m1_cmd(cmd[0]), .m1_addr(addr[0]), .m1_wr_data(wd[0]),
    .m1_data_mask(mk[0]), .m1_ack(ack[0]), .m1_rd_data_valid(rdv_o[0]),
    .m2_req(req[1]), .m2_cmd(cmd[1]), .m2_addr(addr[1]), .m2_wr_data(wd[1]),
    .m2_data_mask(mk[1]), .m2_ack(ack[1]), .m2_rd_data_valid(rdv_o[1]),
    .rd_data_out(rd_data_out), .mem_cmd(mem_cmd), .mem_cmd_en(mem_cmd_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_data_mask(mem_data_mask),
    .rd_data(rdd), .rd_data_valid(rdv_i), .tag_error(tag_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input int m);
    item_t it;
    int w;
    forever begin
      @(posedge clk); #1;
      if (!sys_resetn || ncmd[m] == 0) begin req[m] = 1'b0; continue; end
      it.cmd = mode[m] == 3 ? 1'b1 : mode[m] == 2 ? 1'b0 : 1'($urandom_range(0, 1));
      it.addr = fix_addr[m] >= 0 ? 21'(fix_addr[m]) : 21'($urandom);
      for (int k = 0; k < 4; k++) begin
        it.d[k] = pat_wd ? 64'(10 + k) : {$urandom, $urandom};
        it.mk[k] = pat_wd ? 8'hFF : 8'($urandom);
      end
      if (m == 0) q0.push_back(it); else q1.push_back(it);
      req[m] = 1'b1; cmd[m] = it.cmd; addr[m] = it.addr; wd[m] = it.d[0]; mk[m] = it.mk[0];
      w = 0;
      do begin @(posedge clk); #1; w++; end while (!ack[m] && sys_resetn && w < 3000);
      if (!sys_resetn) begin req[m] = 1'b0; continue; end
      if (!ack[m]) begin
        chk($sformatf("ack_timeout_m%0d", m + 1), 64'(ack[m]), 64'd1);
        req[m] = 1'b0; ncmd[m] = 0; continue;
      end
      req[m] = 1'b0;
      ncmd[m]--;
      for (int k = 1; k < 4; k++) begin @(posedge clk); #1; wd[m] = it.d[k]; mk[m] = it.mk[k]; end
      @(posedge clk); #1; wd[m] = {$urandom, $urandom}; mk[m] = 8'($urandom);
      repeat ($urandom_range(0, gapmax[m])) @(posedge clk);
    end
  endtask

  initial fork drive(0); drive(1); join_none

  // controller stand-in: returns 4 beats for each read command it sees
  initial forever begin
    @(posedge clk); #1;
    rdv_i = 1'b0; rdd = {$urandom, $urandom};
    if (!sys_resetn) begin cpend = 0; cbeat = 0; end
    else begin
      if (mem_cmd_en && !mem_cmd) cpend++;
      if (stray) begin rdv_i = 1'b1; stray = 0; end
      else if (cpend > 0 && !hold && $urandom_range(0, 3) != 0) begin
        rdv_i = 1'b1; cbeat++;
        if (cbeat == 4) begin cbeat = 0; cpend--; end
      end
    end
  end

  initial begin : monitor
    logic [1:0] ea, er;
    logic [63:0] ewd;
    logic [7:0] emk;
    bit popnow, e1, e2;
    forever begin
      @(negedge clk);
      if (!sys_resetn) begin
        chk("reset_outputs", 64'({mem_addr, mem_data_mask, ack, mem_cmd_en, mem_cmd, rdv_o, tag_error}), 64'd0);
        chk("reset_wr_data", mem_wr_data, 64'd0);
        pend_m = -1; last_g = -1000; streak = 0; bcnt = 0; wl = 0; wrec = 0; terr = 0;
        tq.delete(); q0.delete(); q1.delete();
      end else begin
        ea = pend_m == 0 ? 2'b01 : pend_m == 1 ? 2'b10 : 2'b00;
        chk("ack", 64'(ack), 64'(ea));
        chk("cmd_en", 64'(mem_cmd_en), 64'(|ea));
        if (pend_m >= 0) begin
          chk("mem_cmd", 64'(mem_cmd), 64'(pend_it.cmd));
          chk("mem_addr", 64'(mem_addr), 64'(pend_it.addr));
          last_g = cyc; glog.push_back(pend_m); gcyc.push_back(cyc);
          if (pend_it.cmd) begin wl = 4; wrec = 5; wit = pend_it; end
          else tq.push_back(pend_m == 1);
        end
        ewd = wl > 0 ? wit.d[4-wl] : 64'd0;
        emk = wl > 0 ? wit.mk[4-wl] : 8'd0;
        chk("wr_data", mem_wr_data, ewd);
        chk("data_mask", 64'(mem_data_mask), 64'(emk));
        if (wrec > 0) begin wlog.push_back(mem_wr_data); wrec--; end
        er = (rdv_i && tq.size() > 0) ? (tq[0] ? 2'b10 : 2'b01) : 2'b00;
        chk("rd_valid", 64'(rdv_o), 64'(er));
        chk("rd_data_out", rd_data_out, rdd);
        chk("tag_error", 64'(tag_error), 64'(terr));
        if (rdv_o[0]) rdv_cnt[0]++;
        if (rdv_o[1]) rdv_cnt[1]++;
        popnow = 0;
        if (rdv_i) begin
          if (tq.size() == 0) terr = 1;
          else begin bcnt++; if (bcnt == 4) begin bcnt = 0; popnow = 1; end end
        end
        e1 = req[0] && q0.size() > 0 && (cmd[0] || tq.size() < 4);
        e2 = req[1] && q1.size() > 0 && (cmd[1] || tq.size() < 4);
        pend_m = -1;
        if (calib && cyc + 1 - last_g >= 14) begin
          if (e2 && (!e1 || streak == 3)) pend_m = 1; else if (e1) pend_m = 0;
        end
        if (pend_m == 0) pend_it = q0.pop_front(); else if (pend_m == 1) pend_it = q1.pop_front();
        if (!req[1] || pend_m == 1) streak = 0; else if (pend_m == 0 && streak < 3) streak++;
        if (popnow) begin
          void'(tq.pop_front());
          if (pop_arm) begin first_pop = cyc; pop_arm = 0; end
        end
        if (wl > 0) wl--;
      end
    end
  end

  task automatic wait_idle();
    int w = 0;
    while ((ncmd[0] != 0 || ncmd[1] != 0 || req != 0 || cpend != 0 || tq.size() != 0) && w < 6000) begin
      @(posedge clk); #1; w++;
    end
    chk("idle_timeout", 64'(w >= 6000), 64'd0);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3 sys_resetn = 1'b0;
    repeat (3) @(posedge clk);
    #3 sys_resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin : main
    int b, c0, w, r0;
    int pat[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    repeat (3) @(posedge clk);
    #3 sys_resetn = 1'b1;
    @(posedge clk); #1;
    calib = 1'b1;
    // single m1 read at 0x100
    b = rdv_cnt[0]; r0 = rdv_cnt[1];
    fix_addr[0] = 32'h100; mode[0] = 2; ncmd[0] = 1;
    wait_idle();
    chk("t1_m1_beats", 64'(rdv_cnt[0] - b), 64'd4);
    chk("t1_m2_beats", 64'(rdv_cnt[1] - r0), 64'd0);
    fix_addr[0] = -1;
    // both masters requesting back to back
    b = glog.size();
    mode[0] = 3; mode[1] = 3; ncmd[0] = 6; ncmd[1] = 2;
    wait_idle();
    chk("t2_count", 64'(glog.size() - b), 64'd8);
    for (int i = 0; i < 8; i++) if (b + i < glog.size()) chk("t2_order", 64'(glog[b+i]), 64'(pat[i]));
    for (int i = 1; i < 8; i++) if (b + i < gcyc.size()) chk("t2_gap", 64'(gcyc[b+i] - gcyc[b+i-1]), 64'd14);
    // m2 write with beats A..D
    pat_wd = 1; b = wlog.size(); ncmd[1] = 1;
    wait_idle();
    pat_wd = 0;
    chk("t3_wlog", 64'(wlog.size() - b), 64'd5);
    for (int k = 0; k < 5; k++) if (b + k < wlog.size()) chk("t3_beat", wlog[b+k], k < 4 ? 64'(10 + k) : 64'd0);
    // five reads with data held back
    hold = 1; b = glog.size(); mode[0] = 2; ncmd[0] = 5;
    repeat (120) @(posedge clk);
    #1;
    chk("t4_held_grants", 64'(glog.size() - b), 64'd4);
    pop_arm = 1; hold = 0;
    wait_idle();
    chk("t4_all_grants", 64'(glog.size() - b), 64'd5);
    if (glog.size() - b == 5) chk("t4_after_pop", 64'(gcyc[b+4] > first_pop && first_pop >= 0), 64'd1);
    // stray beat sets a sticky tag_error
    stray = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_tag_error", 64'(tag_error), 64'd1);
    mode[0] = 1; mode[1] = 1; ncmd[0] = 3; ncmd[1] = 3; gapmax = '{5, 5};
    wait_idle();
    chk("t5_sticky", 64'(tag_error), 64'd1);
    // reset in the middle of a read burst
    mode[0] = 2; ncmd[0] = 1; w = 0;
    while (!rdv_o[0] && w < 300) begin @(posedge clk); #2; w++; end
    chk("t5_read_started", 64'(w < 300), 64'd1);
    do_reset();
    chk("t5_rst_tag_error", 64'(tag_error), 64'd0);
    b = rdv_cnt[0];
    repeat (20) @(posedge clk);
    #1;
    chk("t5_no_route", 64'(rdv_cnt[0] - b + rdv_cnt[1] - r0 - (rdv_cnt[1] - r0)), 64'd0);
    stray = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_stray_after_rst", 64'(tag_error), 64'd1);
    do_reset();
    // calib low blocks grants; m1 wins the cycle after it rises
    calib = 1'b0; b = glog.size();
    mode[0] = 3; mode[1] = 3; ncmd[0] = 3; ncmd[1] = 3; gapmax = '{0, 0};
    repeat (40) @(posedge clk);
    #1;
    chk("t6_no_grant", 64'(glog.size() - b), 64'd0);
    c0 = cyc; calib = 1'b1;
    wait_idle();
    if (glog.size() > b) begin
      chk("t6_first_cycle", 64'(gcyc[b] - c0), 64'd1);
      chk("t6_first_m1", 64'(glog[b]), 64'd0);
    end else chk("t6_grants", 64'(glog.size() - b), 64'd6);
    // random mixed traffic with calib and data-return stalls
    mode[0] = 1; mode[1] = 1; ncmd[0] = 40; ncmd[1] = 40; gapmax = '{20, 20};
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 99) == 0) calib = ~calib;
      if ($urandom_range(0, 59) == 0) hold = ~hold;
    end
    calib = 1'b1; hold = 0;
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end
endmodule
